// File: rtl/mult16_shift_add_pkg.sv
// ----------------------------------------------------------------------------
// mult16_shift_add_pkg
// Shared definitions for the shift-and-add multiplier slice.
//   state_t        : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand width in bits (product is twice this)
// ----------------------------------------------------------------------------
package mult16_shift_add_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/add16_cla.sv
// ----------------------------------------------------------------------------
// add16_cla
// Unsigned carry-lookahead adder built from 4-bit lookahead groups.
// The group carries are chained from one group to the next.
//   a, b  : WIDTH-bit operands (WIDTH must be a multiple of 4)
//   cin   : carry into bit 0
//   sum   : WIDTH-bit sum
//   cout  : carry out of the top bit
// ----------------------------------------------------------------------------
module add16_cla #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int GROUPS = WIDTH / 4;

   logic [WIDTH-1:0] prop;
   logic [WIDTH-1:0] gen;

   assign prop = a ^ b;
   assign gen  = a & b;

   // Walk the 4-bit groups from the bottom. Inside a group every carry is
   // expanded directly from generate/propagate and the group carry-in, so
   // each group resolves in two gate levels; the group generate/propagate
   // pair then produces the carry handed to the next group.
   always_comb begin
      logic       carry;
      logic [3:0] gg;
      logic [3:0] pp;
      logic [3:0] cc;
      logic       grp_g;
      logic       grp_p;

      sum   = '0;
      carry = cin;
      gg    = '0;
      pp    = '0;
      cc    = '0;
      grp_g = 1'b0;
      grp_p = 1'b0;

      for (int k = 0; k < GROUPS; k++) begin
         gg = gen[4*k +: 4];
         pp = prop[4*k +: 4];

         cc[0] = carry;
         cc[1] = gg[0] | (pp[0] & carry);
         cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & carry);
         cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
               | (pp[2] & pp[1] & pp[0] & carry);

         grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
               | (pp[3] & pp[2] & pp[1] & gg[0]);
         grp_p = &pp;

         sum[4*k +: 4] = pp ^ cc;
         carry         = grp_g | (grp_p & carry);
      end

      cout = carry;
   end

endmodule

// File: rtl/mult16_shift_add.sv
// ----------------------------------------------------------------------------
// mult16_shift_add
// Sequential unsigned multiplier using the classic shift-and-add method.
// One multiplier bit is consumed per clock; an operation takes exactly WIDTH
// RUN cycles regardless of operand values.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : begin a multiply (accepted in IDLE or DONE, ignored in RUN)
//   a        : WIDTH-bit unsigned multiplicand, captured on accepted start
//   b        : WIDTH-bit unsigned multiplier, captured on accepted start
//   busy     : high while an operation is running
//   done     : one-cycle pulse, product valid in that cycle
//   product  : 2*WIDTH-bit result, held until the next completion
// ----------------------------------------------------------------------------
module mult16_shift_add
   import mult16_shift_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state;
   state_t           next_state;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic             last_iter;
   logic             accept;

   // The multiplicand is added only when the current multiplier bit (the
   // LSB of the low half) is set; otherwise the high half passes through.
   assign addend    = lo[0] ? mcand : '0;
   assign last_iter = (count == CW'(WIDTH - 1));
   assign accept    = start && (state == IDLE || state == DONE);

   add16_cla #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (hi),
      .b    (addend),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // State register. busy and done are registered decodes of the next
   // state so both outputs come straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state == RUN);
         done  <= (next_state == DONE);
      end
   end

   // Next-state logic. DONE lasts one cycle unless a new start arrives,
   // which allows back-to-back operations without passing through IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last_iter) next_state = DONE;
         DONE:    next_state = start ? RUN : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath. The (WIDTH+1)-bit add result {cout, sum} is shifted right
   // together with the low half in the same cycle, so the carry lands in the
   // MSB of the high half and the spare carry bit never needs storing.
   // The product is captured from the post-shift value on the final
   // iteration and held until the next completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         hi      <= '0;
         lo      <= '0;
         count   <= '0;
         product <= '0;
      end else if (accept) begin
         mcand <= a;
         hi    <= '0;
         lo    <= b;
         count <= '0;
      end else if (state == RUN) begin
         hi    <= {add_cout, add_sum[WIDTH-1:1]};
         lo    <= {add_sum[0], lo[WIDTH-1:1]};
         count <= count + CW'(1);
         if (last_iter) begin
            product <= {add_cout, add_sum, lo[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_mult16_shift_add.sv
// ----------------------------------------------------------------------------
// tb_mult16_shift_add
// Directed scoreboard bench for mult16_shift_add. The stimulus process pushes
// the hand-computed product and the issue cycle into a queue; the monitor
// pops an entry on every done pulse and checks product, latency and busy.
// ----------------------------------------------------------------------------
module tb_mult16_shift_add;

   localparam int WIDTH   = 16;
   localparam int LATENCY = 16;

   typedef struct {
      logic [2*WIDTH-1:0] prod;
      int                 cyc;
   } exp_t;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;

   exp_t scoreboard[$];
   int   cyc;
   int   total;
   int   bad;

   mult16_shift_add #(
      .WIDTH (WIDTH)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure start-to-done latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
      end
   endtask

   // Called just after a falling edge: drive a start for one rising edge and,
   // if a completion is expected, record the product and the accept cycle.
   task automatic applyStimulus(input logic [WIDTH-1:0] op_a,
                                input logic [WIDTH-1:0] op_b,
                                input logic [2*WIDTH-1:0] exp_prod,
                                input bit expect_done);
      exp_t e;
      a     = op_a;
      b     = op_b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (expect_done) begin
         e.prod = exp_prod;
         e.cyc  = cyc;
         scoreboard.push_back(e);
      end
   endtask

   // Wait until every queued result has been seen and the DUT is idle.
   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while ((scoreboard.size() != 0 || busy || done) && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_drain_timeout"}, 64'(n >= 60), 64'(0));
   endtask

   // Wait (bounded) for the negedge at which done is high.
   task automatic waitDone(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, "_done_timeout"}, 64'(n >= 60), 64'(0));
   endtask

   // Monitor: every done pulse must match the oldest outstanding request in
   // product and latency, and busy must already be low.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (scoreboard.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_done: got done=1 product=0x%0h want no pulse",
                     product);
         end else begin
            e = scoreboard.pop_front();
            checkOutput("product", 64'(product), 64'(e.prod));
            checkOutput("latency", 64'(cyc - e.cyc), 64'(LATENCY));
            checkOutput("busy_at_done", 64'(busy), 64'(0));
         end
      end
   end

   // Directed stimulus sequence.
   initial begin
      cyc   = 0;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;

      #3;
      checkOutput("reset_busy", 64'(busy), 64'(0));
      checkOutput("reset_done", 64'(done), 64'(0));
      checkOutput("reset_product", 64'(product), 64'(0));

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic multiply.
      applyStimulus(16'd3, 16'd5, 32'h0000_000F, 1'b1);
      checkOutput("busy_after_start", 64'(busy), 64'(1));
      waitDrain("basic");

      // Maximum operands.
      @(negedge clk);
      applyStimulus(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1);
      waitDrain("max");

      // Zero multiplicand still takes the full run.
      @(negedge clk);
      applyStimulus(16'h0000, 16'h1234, 32'h0000_0000, 1'b1);
      waitDrain("zero");

      // Multiplier of one.
      @(negedge clk);
      applyStimulus(16'h1234, 16'h0001, 32'h0000_1234, 1'b1);
      waitDrain("one");

      // Start reasserted mid-run with different operands must be ignored.
      @(negedge clk);
      applyStimulus(16'd7, 16'd9, 32'h0000_003F, 1'b1);
      repeat (4) @(negedge clk);
      a     = 16'd2;
      b     = 16'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("busy_ignored_start", 64'(busy), 64'(1));
      waitDrain("ignored_start");

      // Back-to-back: new start in the DONE cycle of 6*7.
      @(negedge clk);
      applyStimulus(16'd6, 16'd7, 32'h0000_002A, 1'b1);
      waitDone("b2b_first");
      applyStimulus(16'd10, 16'd10, 32'h0000_0064, 1'b1);
      checkOutput("b2b_busy", 64'(busy), 64'(1));
      checkOutput("b2b_done_low", 64'(done), 64'(0));
      waitDrain("b2b");

      // Reset in the middle of a run abandons it.
      @(negedge clk);
      applyStimulus(16'h00FF, 16'h0101, 32'h0, 1'b0);
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", 64'(busy), 64'(0));
      checkOutput("midreset_done", 64'(done), 64'(0));
      checkOutput("midreset_product", 64'(product), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (24) @(negedge clk);
      checkOutput("post_reset_idle", 64'(busy), 64'(0));
      applyStimulus(16'd4, 16'd4, 32'h0000_0010, 1'b1);
      waitDrain("after_reset");

      checkOutput("scoreboard_empty", 64'(scoreboard.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
